// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: command encoding and
// width-independent arithmetic helpers.
package pc_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD    = 3'b000,
    CMD_INC     = 3'b001,
    CMD_LOAD    = 3'b010,
    CMD_BRANCH  = 3'b011,
    CMD_CALL    = 3'b100,
    CMD_RET     = 3'b101,
    CMD_CLR_ERR = 3'b110,
    CMD_RSVD    = 3'b111
  } cmd_e;

  // Sign-extends the low w bits of v to 32 bits; callers truncate to their width.
  function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned w);
    logic signed [31:0] s;
    s = signed'(v << (32 - w));
    return unsigned'(s >>> (32 - w));
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: register-array LIFO with an occupancy counter.
// Pushes when full and pops when empty are ignored.
module ras_stack #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    count;

  assign depth = count;
  assign full  = (count == DW'(DEPTH));
  assign empty = (count == '0);
  assign top   = empty ? '0 : mem[AW'(count - DW'(1))];

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + DW'(1);
    end else if (pop && !empty) begin
      count <= count - DW'(1);
    end
  end

  // Storage is intentionally left unreset; only the counter defines validity.
  always_ff @(posedge clk) begin
    if (rst && push && !full) begin
      mem[AW'(count)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, command decode, next-PC mux and sticky
// overflow/underflow flags around a return-address stack.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH     = 13,
  parameter int unsigned      DEPTH     = 8,
  parameter int unsigned      OFF_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 cmd,
  input  logic [WIDTH-1:0]           target,
  input  logic [OFF_W-1:0]           offset,
  output logic [WIDTH-1:0]           pc_out,
  output logic [WIDTH-1:0]           ret_top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] off_ext;
  logic             push;
  logic             pop;
  logic             ovf_nxt;
  logic             unf_nxt;

  assign pc_inc  = pc_out + WIDTH'(1);
  assign off_ext = WIDTH'(sext32(32'(offset), OFF_W));

  always_comb begin
    pc_nxt  = pc_out;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_nxt = ovf;
    unf_nxt = unf;
    if (en) begin
      case (cmd_e'(cmd))
        CMD_INC:    pc_nxt = pc_inc;
        CMD_LOAD:   pc_nxt = target;
        CMD_BRANCH: pc_nxt = pc_out + off_ext;
        CMD_CALL: begin
          if (full) begin
            ovf_nxt = 1'b1;
          end else begin
            push   = 1'b1;
            pc_nxt = target;
          end
        end
        CMD_RET: begin
          if (empty) begin
            unf_nxt = 1'b1;
          end else begin
            pop    = 1'b1;
            pc_nxt = ret_top;
          end
        end
        CMD_CLR_ERR: begin
          ovf_nxt = 1'b0;
          unf_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_out <= RESET_VEC;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      pc_out <= pc_nxt;
      ovf    <= ovf_nxt;
      unf    <= unf_nxt;
    end
  end

  ras_stack #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .top      (ret_top),
    .depth    (depth),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a behavioural model pushes expected state
// into a scoreboard queue as each command is driven; it is popped after the edge.
module tb_pc_unit;

  localparam int unsigned W  = 13;
  localparam int unsigned D  = 8;
  localparam int unsigned OW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    cmd;
  logic [W-1:0]  target;
  logic [OW-1:0] offset;

  logic [W-1:0]  pc_out, ret_top;
  logic [3:0]    depth;
  logic          full, empty, ovf, unf;

  logic [W-1:0]  rv_pc_out, rv_ret_top;
  logic [3:0]    rv_depth;
  logic          rv_full, rv_empty, rv_ovf, rv_unf;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(W), .DEPTH(D), .OFF_W(OW), .RESET_VEC(13'h000)) dut (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .target(target), .offset(offset),
    .pc_out(pc_out), .ret_top(ret_top), .depth(depth), .full(full),
    .empty(empty), .ovf(ovf), .unf(unf)
  );

  pc_unit #(.WIDTH(W), .DEPTH(D), .OFF_W(OW), .RESET_VEC(13'h100)) dut_rv (
    .clk(clk), .rst(rst), .en(en), .cmd(cmd), .target(target), .offset(offset),
    .pc_out(rv_pc_out), .ret_top(rv_ret_top), .depth(rv_depth), .full(rv_full),
    .empty(rv_empty), .ovf(rv_ovf), .unf(rv_unf)
  );

  typedef struct {
    logic [W-1:0] pc;
    logic [3:0]   depth;
    logic         ovf;
    logic         unf;
    logic [W-1:0] top;
  } exp_t;

  exp_t sb[$];

  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk [D];
  int unsigned  m_depth;
  logic         m_ovf, m_unf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [2:0] c,
                            input logic [W-1:0] t, input logic [OW-1:0] o);
    logic [W-1:0] sx;
    sx = {{(W-OW){o[OW-1]}}, o};
    if (!r) begin
      m_pc = '0; m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (e) begin
      case (c)
        3'd1: m_pc = m_pc + 13'd1;
        3'd2: m_pc = t;
        3'd3: m_pc = m_pc + sx;
        3'd4: begin
          if (m_depth == D) m_ovf = 1'b1;
          else begin
            m_stk[m_depth] = m_pc + 13'd1;
            m_depth++;
            m_pc = t;
          end
        end
        3'd5: begin
          if (m_depth == 0) m_unf = 1'b1;
          else begin
            m_depth--;
            m_pc = m_stk[m_depth];
          end
        end
        3'd6: begin m_ovf = 1'b0; m_unf = 1'b0; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] c,
                      input logic [W-1:0] t, input logic [OW-1:0] o);
    exp_t x;
    rst = r; en = e; cmd = c; target = t; offset = o;
    model_step(r, e, c, t, o);
    x.pc = m_pc; x.depth = 4'(m_depth); x.ovf = m_ovf; x.unf = m_unf;
    x.top = (m_depth > 0) ? m_stk[m_depth-1] : '0;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      x = sb.pop_front();
      check_eq("pc", 32'(pc_out), 32'(x.pc));
      check_eq("depth", 32'(depth), 32'(x.depth));
      check_eq("ovf", 32'(ovf), 32'(x.ovf));
      check_eq("unf", 32'(unf), 32'(x.unf));
      check_eq("full", 32'(full), 32'(x.depth == 4'(D)));
      check_eq("empty", 32'(empty), 32'(x.depth == 4'd0));
      if (x.depth != 0) check_eq("ret_top", 32'(ret_top), 32'(x.top));
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; cmd = '0; target = '0; offset = '0;
    @(posedge clk); #1;

    // Reset and increment
    step(1'b0, 1'b1, 3'd2, 13'h555, 8'h00);
    check_eq("rv_pc_reset", 32'(rv_pc_out), 32'h100);
    check_eq("rv_empty_reset", 32'(rv_empty), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd1, '0, '0);
    check_eq("inc3_pc", 32'(pc_out), 32'd3);

    // Wrap and negative branch
    step(1'b1, 1'b1, 3'd2, 13'h1FFF, '0);
    step(1'b1, 1'b1, 3'd1, '0, '0);
    check_eq("wrap_pc", 32'(pc_out), 32'h0);
    step(1'b1, 1'b1, 3'd2, 13'h0010, '0);
    step(1'b1, 1'b1, 3'd3, '0, 8'hFE);
    check_eq("branch_neg_pc", 32'(pc_out), 32'h000E);
    step(1'b1, 1'b1, 3'd3, '0, 8'h7F);

    // Nested call / return
    step(1'b1, 1'b1, 3'd2, 13'h0020, '0);
    step(1'b1, 1'b1, 3'd4, 13'h0100, '0);
    step(1'b1, 1'b1, 3'd4, 13'h0200, '0);
    step(1'b1, 1'b1, 3'd5, '0, '0);
    check_eq("ret1_pc", 32'(pc_out), 32'h101);
    step(1'b1, 1'b1, 3'd5, '0, '0);
    check_eq("ret2_pc", 32'(pc_out), 32'h21);

    // Overflow, error clear, full drain, then underflow
    for (int i = 0; i <= int'(D); i++) step(1'b1, 1'b1, 3'd4, 13'(13'h300 + 16*i), '0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    step(1'b1, 1'b1, 3'd6, '0, '0);
    check_eq("ovf_clr_full", 32'(full), 32'd1);
    for (int i = 0; i <= int'(D); i++) step(1'b1, 1'b1, 3'd5, '0, '0);
    step(1'b1, 1'b1, 3'd7, 13'h77, 8'h11);

    // RET at reset, en=0 holds everything
    step(1'b0, 1'b1, 3'd0, '0, '0);
    step(1'b1, 1'b1, 3'd5, '0, '0);
    step(1'b1, 1'b0, 3'd6, '0, '0);
    step(1'b1, 1'b0, 3'd2, 13'h55, '0);
    step(1'b1, 1'b1, 3'd6, '0, '0);

    // Reset with entries stacked
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd4, 13'(13'h40 + i), '0);
    step(1'b0, 1'b1, 3'd4, 13'h999, '0);
    check_eq("rv_pc_midreset", 32'(rv_pc_out), 32'h100);
    step(1'b1, 1'b1, 3'd5, '0, '0);
    check_eq("rv_unf_after_reset", 32'(rv_unf), 32'd1);
    check_eq("rv_pc_after_ret", 32'(rv_pc_out), 32'h100);

    // Random command mix
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) != 0),
           3'($urandom_range(0, 7)), 13'($urandom), 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle CPU: a WIDTH-bit PC register with hold, increment, absolute load, signed relative branch, call and return. Call and return use an internal return-address stack of DEPTH entries. Overflow and underflow are reported through sticky error flags. The control FSM drives it one command per cycle, and its PC output feeds the instruction-memory address path.

## Interface
Parameters:
- WIDTH, 13, PC and address width
- DEPTH, 8, return-address stack entries (≥1)
- OFF_W, 8, branch offset width, two's complement (OFF_W ≤ WIDTH)
- RESET_VEC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- en  in  1  command enable; when 0 all state holds
- cmd  in  3  command (encoding below)
- target  in  WIDTH  absolute address for LOAD/CALL
- offset  in  OFF_W  signed relative offset for BRANCH
- pc_out  out  WIDTH  current PC (registered)
- ret_top  out  WIDTH  stack top entry; undefined when empty
- depth  out  $clog2(DEPTH+1)  number of stacked entries
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- ovf  out  1  sticky: CALL attempted while full
- unf  out  1  sticky: RET attempted while empty

## Operation
Commands (applied only when en=1):
- 000 HOLD: no change
- 001 INC: pc ← pc+1
- 010 LOAD: pc ← target
- 011 BRANCH: pc ← pc + sign_extend(offset)
- 100 CALL: push pc+1; pc ← target
- 101 RET: pop; pc ← popped value
- 110 CLR_ERR: ovf ← 0, unf ← 0; pc unchanged
- 111: reserved, behaves as HOLD

Arithmetic and stack rules:
- All PC arithmetic is modulo 2^WIDTH; carries are discarded.
- Offset is sign-extended from OFF_W to WIDTH.
- CALL while full: no push, pc unchanged, depth unchanged, ovf ← 1.
- RET while empty: no pop, pc unchanged, unf ← 1.
- Pushed value is pc+1 taken from the pre-update pc, wrapped (pc = 2^WIDTH−1 pushes 0).
- Stack is LIFO. ret_top is the entry at index depth−1.
- Flags stay set until CLR_ERR or reset; a new error while set keeps the flag at 1.

## Timing
- Single clock. Every output is a register, or decoded combinationally from registers only (full, empty, ret_top); no input-to-output combinational path.
- Latency 1: command sampled on edge N appears on pc_out, depth and flags after edge N.
- Back-to-back commands are accepted every cycle with no bubbles. CALL followed by RET in the next cycle returns pc+1 of the original pc.
- Reset (rst=0 at an edge) wins over en/cmd:
  - pc_out = RESET_VEC, depth = 0, empty = 1, full = 0, ovf = unf = 0.
  - Stack storage contents are not reset and are don't-care.
- Reset mid-sequence (e.g. with entries stacked) discards all stack entries. The first RET after reset sets unf.
- en=0 with any cmd, including CLR_ERR: no state change.

## Structure
- Shared package pc_pkg:
  - cmd encoding constants CMD_HOLD … CMD_CLR_ERR
  - width-independent helpers, such as the sign-extend function
- Sub-module ras_stack, parametrised by WIDTH and DEPTH:
  - ports push, pop, push_data, top, depth, full, empty
  - register-array storage plus stack pointer
  - ignores a push when full and a pop when empty
- pc_unit holds the PC register, command decode, next-PC mux and error flags.

## Test plan
- Reset, then INC ×3 → pc_out 0,1,2,3; with RESET_VEC=0x100, rst low then high → pc_out 0x100, empty=1.
- LOAD 0x1FFF (WIDTH=13), then INC → pc_out 0x0000 (wrap). BRANCH with offset 0xFE at pc 0x0010 → pc_out 0x000E.
- At pc 0x20, CALL 0x100, then at 0x100 CALL 0x200, then RET, RET:
  - pc_out sequence 0x100, 0x200, 0x101, 0x21
  - depth sequence 1, 2, 1, 0
- DEPTH+1 CALLs → the last one leaves pc unchanged, full=1, ovf=1; CLR_ERR → ovf=0, full still 1.
- RET at reset → unf=1, pc unchanged. en=0 with LOAD 0x55 → pc unchanged.
- Push 3 entries, assert rst mid-stream → depth=0, pc=RESET_VEC. The next RET sets unf and leaves pc at RESET_VEC.
